// File: rtl/risc_v_pkg.sv
// -----------------------------------------------------------------------------
// risc_v_pkg
// Shared types and encodings for the multi-cycle RV32I controller:
//   - state_t        : controller FSM states (4-bit state register)
//   - OP_*           : supported opcode values (IR[6:0])
//   - ALUC_*         : ALUControl codes presented to the ALU
//   - ALUOP_*        : internal ALUOp codes between FSM and ALU decoder
//   - RES_* / SRCA_* / SRCB_* : datapath mux select encodings
// -----------------------------------------------------------------------------
package risc_v_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALUControl codes
  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc encodings
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational mapping from ALUOp (+ instruction fields) to ALUControl.
// Ports:
//   alu_op      in  2  ALUOp from the controller FSM (add / sub / funct)
//   funct3      in  3  IR[14:12]
//   op_5        in  1  IR[5], distinguishes R-type (1) from I-type (0)
//   funct7_5    in  1  IR[30]
//   alu_control out 3  ALUControl to the ALU
// -----------------------------------------------------------------------------
module alu_decoder
  import risc_v_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op_5,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALUC_ADD;
    unique case (alu_op)
      ALUOP_ADD: alu_control = ALUC_ADD;
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type can subtract; addi with IR[30]=1 is still an add.
          3'b000:  alu_control = (op_5 && funct7_5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  alu_control = ALUC_SLT;
          3'b110:  alu_control = ALUC_OR;
          3'b111:  alu_control = ALUC_AND;
          default: alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Sequencing controller for the multi-cycle RV32I core. A Moore-style FSM
// (4-bit state register) steps the shared ALU, unified memory port, register
// file and PC/IR through fetch/decode/execute/memory/writeback. Memory
// accesses wait on MemReady.
// Ports:
//   CLK        in   1  clock, rising edge
//   RST        in   1  synchronous active-low reset
//   op         in   7  IR[6:0]
//   funct3     in   3  IR[14:12]
//   funct7_5   in   1  IR[30]
//   Zero       in   1  ALU zero flag
//   MemReady   in   1  memory completes access this cycle
//   PCWrite    out  1  PC enable
//   AdrSrc     out  1  memory address select (0=PC, 1=ALUOut)
//   MemWrite   out  1  memory write strobe
//   IRWrite    out  1  IR/OldPC enable
//   ResultSrc  out  2  result mux select
//   ALUSrcA    out  2  ALU A mux select
//   ALUSrcB    out  2  ALU B mux select
//   ALUControl out  3  ALU operation
//   ImmSrc     out  2  immediate format (from op only)
//   RegWrite   out  1  register file write enable
//   Illegal    out  1  pulse on unsupported opcode (in DECODE)
//   Retire     out  1  pulse when an instruction completes
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import risc_v_pkg::*;
#(
  parameter int OP_WIDTH       = 7,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int IMM_SRC_WIDTH  = 2,
  parameter int ALU_OP_WIDTH   = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [OP_WIDTH-1:0]       op,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic                      funct7_5,
  input  logic                      Zero,
  input  logic                      MemReady,
  output logic                      PCWrite,
  output logic                      AdrSrc,
  output logic                      MemWrite,
  output logic                      IRWrite,
  output logic [1:0]                ResultSrc,
  output logic [1:0]                ALUSrcA,
  output logic [1:0]                ALUSrcB,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  output logic [IMM_SRC_WIDTH-1:0]  ImmSrc,
  output logic                      RegWrite,
  output logic                      Illegal,
  output logic                      Retire
);

  state_t                  state_reg;
  state_t                  state_next;
  logic [ALU_OP_WIDTH-1:0] alu_op;

  always_ff @(posedge CLK) begin
    if (!RST) state_reg <= S_FETCH;
    else      state_reg <= state_next;
  end

  // Next state and state-decoded outputs. The reset override at the end
  // kills all enables in the same cycle RST is low, even mid-instruction.
  always_comb begin
    state_next = state_reg;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    Illegal    = 1'b0;
    Retire     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    alu_op     = ALUOP_ADD;

    case (state_reg)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target PC+imm is computed here and lands in ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BRANCH:    state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          default: begin
            Illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        Retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe stays up until the memory accepts the write.
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        Retire   = MemReady;
        if (MemReady) state_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        Retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        // beq takes on Zero, bne on !Zero; other branch kinds never take.
        PCWrite    = (funct3[FUNCT3_WIDTH-1:1] == '0) ? (Zero ^ funct3[0]) : 1'b0;
        Retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC <- target held in ALUOut; ALU forms OldPC+4 for the link.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase

    if (!RST) begin
      state_next = S_FETCH;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      Illegal    = 1'b0;
      Retire     = 1'b0;
      ResultSrc  = RES_ALURESULT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_FOUR;
      alu_op     = ALUOP_ADD;
    end
  end

  // Immediate format depends only on the opcode.
  always_comb begin
    case (op)
      OP_SW:     ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_5        (op[5]),
    .funct7_5    (funct7_5),
    .alu_control (ALUControl)
  );

endmodule
